// File: rtl/adder_28_pipe.sv
// Registered 4+4-bit unsigned ripple-carry adder with valid-qualified output.
// Define ADDER_28_PIPE_INREG_EN to add an input register stage (latency 2 instead of 1).
module adder_28_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] pi,
    output logic [4:0] po,
    output logic       out_valid
);

    function automatic logic [4:0] ripple_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] c;
        logic [3:0] s;
        c[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        return {c[4], s};
    endfunction

    logic [7:0] core_pi;
    logic       core_vld;

`ifdef ADDER_28_PIPE_INREG_EN
    logic [7:0] pi_q, pi_d;
    logic       valid_q, valid_d;

    always_comb begin
        pi_d    = in_valid ? pi : pi_q;
        valid_d = in_valid;
    end

    // Input stage: operands captured on valid only, valid tracked every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pi_q    <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            pi_q    <= pi_d;
            valid_q <= valid_d;
        end
    end

    assign core_pi  = pi_q;
    assign core_vld = valid_q;
`else
    assign core_pi  = pi;
    assign core_vld = in_valid;
`endif

    logic [4:0] po_q, po_d;
    logic       out_valid_q, out_valid_d;

    always_comb begin
        po_d        = core_vld ? ripple_add(core_pi[7:4], core_pi[3:0]) : po_q;
        out_valid_d = core_vld;
    end

    // Output stage: sum holds across invalid cycles, valid is a per-cycle flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            po_q        <= 5'b00000;
            out_valid_q <= 1'b0;
        end else begin
            po_q        <= po_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign po        = po_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_28_pipe.sv
// Scoreboard testbench for adder_28_pipe; latency follows ADDER_28_PIPE_INREG_EN.
module tb_adder_28_pipe;

`ifdef ADDER_28_PIPE_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] pi;
    logic [4:0] po;
    logic       out_valid;

    typedef struct {
        logic [4:0] sum;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic       last_rst = 1'b0;
    logic [4:0] po_model = 5'b00000;

    adder_28_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .pi       (pi),
        .po       (po),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_rst <= rst;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Stale expectations are discarded once a reset edge has gone by.
    task automatic drive(input logic v, input logic [7:0] p, input logic r, input logic [4:0] e);
        exp_t item;
        @(posedge clk);
        #1;
        if (last_rst) exp_q.delete();
        rst      = r;
        in_valid = v;
        pi       = p;
        if (v && !r) begin
            item.sum = e;
            item.due = cyc + LAT;
            exp_q.push_back(item);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (last_rst) begin
                check("rst_po", 32'(po), 32'd0);
                check("rst_vld", 32'(out_valid), 32'd0);
                po_model = 5'b00000;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_vld", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 32'(po), 32'(e.sum));
                    check("lat", 32'(cyc), 32'(e.due));
                    po_model = e.sum;
                end
            end else begin
                check("hold", 32'(po), 32'(po_model));
            end
        end
    end

    logic [7:0] corner_pi [8] = '{8'h00, 8'h01, 8'h10, 8'hFF, 8'h8F, 8'h88, 8'h1F, 8'hF1};
    logic [4:0] corner_po [8] = '{5'b00000, 5'b00001, 5'b00001, 5'b11110,
                                  5'b10111, 5'b10000, 5'b10000, 5'b10000};

    initial begin
        logic [7:0] p;
        rst      = 1'b1;
        in_valid = 1'b1;
        pi       = 8'hFF;
        drive(1'b1, 8'hFF, 1'b1, 5'd0);
        drive(1'b1, 8'h00, 1'b0, 5'b00000);
        drive(1'b0, 8'h00, 1'b0, 5'd0);
        drive(1'b0, 8'h00, 1'b0, 5'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, corner_pi[i], 1'b0, corner_po[i]);
            drive(1'b0, 8'h00, 1'b0, 5'd0);
        end

        drive(1'b1, 8'h37, 1'b0, 5'b01010);
        drive(1'b1, 8'hE9, 1'b0, 5'b10111);
        for (int i = 0; i < 256; i++) begin
            p = 8'(i);
            drive(1'b1, p, 1'b0, 5'(p[7:4]) + 5'(p[3:0]));
        end

        drive(1'b1, 8'h22, 1'b0, 5'b00100);
        for (int i = 0; i < 4; i++) drive(1'b0, 8'hFF, 1'b0, 5'd0);

        for (int i = 0; i < 5; i++) begin
            p = 8'(8'h5A + 8'(i * 17));
            drive(1'b1, p, 1'b0, 5'(p[7:4]) + 5'(p[3:0]));
        end
        drive(1'b1, 8'hEE, 1'b1, 5'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 8'hFF, 1'b0, 5'd0);
        drive(1'b1, 8'h43, 1'b0, 5'b00111);
        drive(1'b1, 8'hC6, 1'b0, 5'b10010);

        for (int i = 0; i < LAT + 3; i++) drive(1'b0, 8'h00, 1'b0, 5'd0);
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
